// File: rtl/paso8bto32b_pkg.sv
// rtl/paso8bto32b_pkg.sv - shared lane constants for the 32b/8b link
// Purpose: constants shared by the 32b->8b serializer and the 8b->32b packer
//          so both ends agree on byte width and lane order (MSB lane first).
// Ports:   none (package).
package paso8bto32b_pkg;

  localparam int P_BYTE_W         = 8;
  localparam int P_BYTES_PER_WORD = 4;
  localparam int P_WORD_W         = P_BYTE_W * P_BYTES_PER_WORD;
  localparam int P_IDX_W          = 2;

endpackage

// File: rtl/paso8bto32b.sv
// rtl/paso8bto32b.sv - byte-to-word packer, MSB byte first, 4f clock domain
// Purpose: rebuilds 32-bit words from the serializer's byte stream; one
//          registered word plus a single-cycle valid pulse per four bytes.
// Ports:
//   clk_4f      in   fast byte clock, all logic on its rising edge
//   reset       in   synchronous active-high reset
//   data_in     in   incoming byte
//   valid_in    in   data_in carries a byte this cycle
//   data_out    out  last completed word, first byte received in the top lane
//   valid_out   out  one-cycle pulse when data_out holds a new word
//   indice_out  out  lane index of the next byte to be accepted
//   partial     out  a word is partially assembled (indice_out != 0)
//   word_count  out  completed words since reset, saturating
module paso8bto32b
  import paso8bto32b_pkg::*;
#(
  parameter int BYTE_W         = P_BYTE_W,
  parameter int BYTES_PER_WORD = P_BYTES_PER_WORD,
  parameter int CNT_W          = 16
) (
  input  logic                             clk_4f,
  input  logic                             reset,
  input  logic [BYTE_W-1:0]                data_in,
  input  logic                             valid_in,
  output logic [BYTES_PER_WORD*BYTE_W-1:0] data_out,
  output logic                             valid_out,
  output logic [P_IDX_W-1:0]               indice_out,
  output logic                             partial,
  output logic [CNT_W-1:0]                 word_count
);

  localparam int L_WORD_W = BYTES_PER_WORD * BYTE_W;
  localparam logic [P_IDX_W-1:0] L_LAST_IDX = P_IDX_W'(BYTES_PER_WORD - 1);

  logic [P_IDX_W-1:0]  r_indice;
  logic [L_WORD_W-1:0] r_acc;
  logic [L_WORD_W-1:0] r_data;
  logic                r_valid;
  logic [CNT_W-1:0]    r_word_count;

  logic [L_WORD_W-1:0] w_byte_placed;
  logic [L_WORD_W-1:0] w_acc_next;
  logic                w_complete;

  // Lanes at and below the current index are always zero in r_acc (it is
  // cleared on completion and reset), so OR-ing the placed byte is enough.
  // On the last index this yields {acc[top lanes], data_in}, the full word.
  always_comb begin
    w_byte_placed = '0;
    w_acc_next    = '0;
    w_complete    = 1'b0;
    w_byte_placed = {data_in, {(L_WORD_W-BYTE_W){1'b0}}} >> (BYTE_W * int'(r_indice));
    w_acc_next    = r_acc | w_byte_placed;
    w_complete    = valid_in && (r_indice == L_LAST_IDX);
  end

  // Index / accumulator / output word. A low valid_in holds everything but
  // valid_out, so a gap never loses a partial word.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_indice <= '0;
      r_acc    <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_complete) begin
        r_data   <= w_acc_next;
        r_valid  <= 1'b1;
        r_indice <= '0;
        r_acc    <= '0;
      end else if (valid_in) begin
        r_acc    <= w_acc_next;
        r_indice <= r_indice + P_IDX_W'(1);
      end
    end
  end

  // Completed-word counter, sticks at all-ones.
  always_ff @(posedge clk_4f) begin
    if (reset) begin
      r_word_count <= '0;
    end else if (w_complete && (r_word_count != {CNT_W{1'b1}})) begin
      r_word_count <= r_word_count + CNT_W'(1);
    end
  end

  assign data_out   = r_data;
  assign valid_out  = r_valid;
  assign indice_out = r_indice;
  assign partial    = (r_indice != '0);
  assign word_count = r_word_count;

endmodule

// File: tb/tb_paso8bto32b.sv
// tb/tb_paso8bto32b.sv - scoreboard bench for the byte-to-word packer
module tb_paso8bto32b;

  typedef struct {
    logic [31:0] data;
    logic [15:0] cnt;
  } exp_t;

  logic        clk_4f = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        valid_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic [1:0]  indice_out;
  logic        partial;
  logic [15:0] word_count;

  logic [31:0] data_out4;
  logic        valid_out4;
  logic [1:0]  indice_out4;
  logic        partial4;
  logic [3:0]  word_count4;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          pulses4 = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk_4f = ~clk_4f;

  paso8bto32b #(.BYTE_W(8), .BYTES_PER_WORD(4), .CNT_W(16)) dut (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out), .valid_out(valid_out), .indice_out(indice_out),
    .partial(partial), .word_count(word_count)
  );

  paso8bto32b #(.BYTE_W(8), .BYTES_PER_WORD(4), .CNT_W(4)) dut4 (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .data_out(data_out4), .valid_out(valid_out4), .indice_out(indice_out4),
    .partial(partial4), .word_count(word_count4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every valid_out pulse must match the oldest expected word.
  always @(negedge clk_4f) begin
    exp_t e;
    if (valid_out === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pulse: got data_out %h, required no pulse", data_out);
      end else begin
        e = sb_q.pop_front();
        check("data_out", data_out, e.data);
        check("word_count_at_pulse", {16'd0, word_count}, {16'd0, e.cnt});
      end
    end
    if (valid_out4 === 1'b1) pulses4++;
  end

  // Stimulus is driven 1 time unit after the rising edge; each call
  // presents one cycle of input and returns just after it was sampled.
  task automatic cyc(input logic v, input logic [7:0] b);
    valid_in = v;
    data_in  = b;
    @(posedge clk_4f);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    valid_in = 1'b1;      // reset must win over a valid byte
    data_in  = 8'hBE;
    @(posedge clk_4f);
    #1;
    reset    = 1'b0;
    valid_in = 1'b0;
    exp_cnt  = 16'd0;
    pulses4  = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    exp_t e;
    for (int i = 3; i >= 0; i--) begin
      if (i == 0) begin
        exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
        e.data  = w;
        e.cnt   = exp_cnt;
        sb_q.push_back(e);
      end
      cyc(1'b1, w[i*8 +: 8]);
    end
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = 8'h00;
    repeat (2) @(posedge clk_4f);
    #1;
    reset = 1'b0;

    // reset state
    check("rst_data_out",   data_out, 32'h0);
    check("rst_valid_out",  {31'd0, valid_out}, 32'd0);
    check("rst_word_count", {16'd0, word_count}, 32'd0);
    check("rst_indice",     {30'd0, indice_out}, 32'd0);
    check("rst_partial",    {31'd0, partial}, 32'd0);

    // single word
    send_word(32'hDEADBEEF);
    check("w1_indice", {30'd0, indice_out}, 32'd0);
    check("w1_count",  {16'd0, word_count}, 32'd1);
    cyc(1'b0, 8'h00);

    // word split by a 3-cycle gap
    cyc(1'b1, 8'h11);
    check("gap_indice1", {30'd0, indice_out}, 32'd1);
    cyc(1'b1, 8'h22);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'hFF);
      check("gap_partial", {31'd0, partial}, 32'd1);
      check("gap_indice",  {30'd0, indice_out}, 32'd2);
      check("gap_hold",    data_out, 32'hDEADBEEF);
    end
    begin
      exp_t e;
      exp_cnt = exp_cnt + 16'd1;
      e.data = 32'h11223344;
      e.cnt  = exp_cnt;
      cyc(1'b1, 8'h33);
      sb_q.push_back(e);
      cyc(1'b1, 8'h44);
    end
    check("gap_partial_end", {31'd0, partial}, 32'd0);
    cyc(1'b0, 8'h00);

    // back-to-back words with valid held high
    do_reset();
    send_word(32'h01020304);
    send_word(32'hA5A55A5A);
    cyc(1'b0, 8'h00);
    check("b2b_count", {16'd0, word_count}, 32'd2);
    check("b2b_hold",  data_out, 32'hA5A55A5A);

    // reset mid-word discards the partial word
    cyc(1'b1, 8'hCA);
    cyc(1'b1, 8'hFE);
    do_reset();
    check("mid_rst_indice",  {30'd0, indice_out}, 32'd0);
    check("mid_rst_partial", {31'd0, partial}, 32'd0);
    check("mid_rst_data",    data_out, 32'h0);
    send_word(32'h12345678);
    cyc(1'b0, 8'h00);
    check("mid_rst_count", {16'd0, word_count}, 32'd1);

    // idle after reset
    do_reset();
    repeat (20) cyc(1'b0, 8'h5A);
    check("idle_data_out", data_out, 32'h0);
    check("idle_indice",   {30'd0, indice_out}, 32'd0);
    check("idle_count",    {16'd0, word_count}, 32'd0);

    // 17 words: 16-bit counter reaches 17, 4-bit counter sticks at 15
    do_reset();
    for (int k = 0; k < 17; k++) begin
      logic [7:0] b;
      b = 8'(k * 4);
      send_word({b, b + 8'd1, b + 8'd2, b + 8'd3});
    end
    cyc(1'b0, 8'h00);
    cyc(1'b0, 8'h00);
    check("sat_count4",  {28'd0, word_count4}, 32'd15);
    check("sat_pulses4", pulses4, 32'd17);
    check("sat_count16", {16'd0, word_count}, 32'd17);
    check("sat_data4",   data_out4, 32'h40414243);

    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/paso8bto32b.md
# paso8bto32b

Byte-to-word packer on the receive side of the link: it consumes the byte stream and per-byte valid produced by the 32b→8b serializer and rebuilds the original 32-bit words, most-significant byte first. It runs entirely in the fast (4f) clock domain, emits one registered word with a single-cycle valid pulse per four accepted bytes, and exposes byte-alignment and word-count status for the test bench and downstream 32-bit stages.

## Interface
Parameters:
- BYTE_W, 8, width of one input byte
- BYTES_PER_WORD, 4, bytes packed per output word (fixed at 4 in this design; index width 2)
- CNT_W, 16, width of the received-word counter

Ports:
- clk_4f  input  1  single clock (fast byte clock); all logic on its rising edge
- reset  input  1  synchronous, active-high reset
- data_in  input  8  incoming byte
- valid_in  input  1  data_in carries a byte this cycle
- data_out  output  32  last completed word, first byte received in [31:24]
- valid_out  output  1  one-cycle pulse: data_out holds a newly completed word
- indice_out  output  2  position of the next byte to be accepted (0..3)
- partial  output  1  high while a word is partially assembled (indice_out != 0)
- word_count  output  CNT_W  number of completed words since reset, saturating

## Operation
- Reset (sampled at the rising edge of clk_4f with reset=1): indice=0, accumulator=0, data_out=0, valid_out=0, word_count=0, partial=0. Reset overrides valid_in in the same cycle.
- Byte placement: indice 0 → acc[31:24], 1 → acc[23:16], 2 → acc[15:8], 3 → completes the word.
- valid_in=1, indice 0..2: store byte into its lane, indice+1, valid_out=0.
- valid_in=1, indice 3: data_out ← {acc[31:8], data_in}, valid_out=1, indice wraps to 0, word_count+1 (held at 2^CNT_W−1 once reached), acc cleared.
- valid_in=0: indice, acc, data_out and word_count are held; valid_out=0. A gap in valid_in never discards a partial word; assembly resumes at the held indice, matching the serializer, which also holds its byte index while its valid is low.
- data_out changes only on a completion cycle; between pulses it holds the previous word.
- Reset mid-word: the partial word is discarded, no valid_out pulse is generated for it, and the next accepted byte goes to [31:24].
- partial is combinational from indice (indice != 0); indice_out mirrors indice.

## Timing
- valid_out rises on the clk_4f edge that samples the 4th byte and is high for exactly one cycle, unless another word completes on the very next edge, which cannot happen (minimum 4 accepted bytes per word).
- Latency: 1 cycle from the 4th byte at the input to data_out/valid_out.
- Throughput: one word per 4 cycles with continuous valid_in.
- The serializer's output is registered, so cascading it with this block gives 2 cycles from the serializer sampling its last byte to the rebuilt word on data_out.
- Registered outputs: data_out, valid_out, word_count, indice_out.

## Structure
- Shared package constants: BYTE_W=8, BYTES_PER_WORD=4, WORD_W=32, IDX_W=2. These are shared with the 32b→8b serializer so that both ends agree on lane order.
- No sub-module is needed; one always block holds the index/accumulator and one holds the saturating counter.
- Target size is about 120–160 lines of RTL including the counter.

## Test plan
- Reset then 4 consecutive bytes 0xDE,0xAD,0xBE,0xEF → valid_out pulses once, data_out=0xDEADBEEF, word_count=1, indice_out=0.
- Bytes 0x11,0x22, valid_in low 3 cycles, then 0x33,0x44 → partial=1 during the gap, single pulse with data_out=0x11223344.
- Loopback from the serializer fed 0x01020304 then 0xA5A5_5A5A with valid held high → data_out matches each word 2 cycles after the serializer's last byte; word_count=2.
- Reset asserted after 2 bytes of 0xCAFE…, followed by 0x12,0x34,0x56,0x78 → no pulse for the aborted word, data_out=0x12345678, word_count=1.
- CNT_W=4 with 17 full words → word_count saturates at 15; valid_out still pulses 17 times.
- valid_in=0 held for 20 cycles after reset → data_out=0, valid_out never asserted, indice_out=0.
